// File: rtl/sr_latch_monitor.sv
// Clocked observer for an SR latch: synchronises Q/Q_BAR, classifies the latch
// state, counts SET/RESET entries and flags sustained invalid (Q == Q_BAR) conditions.
module sr_latch_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int INVALID_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             qbar_in,
    input  logic             clr_counts,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] set_count,
    output logic [CNT_W-1:0] reset_count,
    output logic             change_pulse,
    output logic             invalid_pulse,
    output logic             invalid_flag
);

    localparam int BAD_W = $clog2(INVALID_LIM + 1);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_SET     = 2'b01,
        ST_RESET   = 2'b10,
        ST_INVALID = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] q_sync;
    logic [SYNC_STAGES-1:0] qbar_sync;
    logic                   qs;
    logic                   qbs;
    logic [BAD_W-1:0]       bad_cnt;
    state_t                 state_r;
    state_t                 state_nxt;
    logic                   good_set;
    logic                   good_reset;
    logic                   bad;
    logic                   at_limit;
    logic                   enter_set;
    logic                   enter_reset;
    logic                   enter_invalid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [BAD_W-1:0] bad_inc(input logic [BAD_W-1:0] v);
        return (v >= BAD_W'(INVALID_LIM)) ? BAD_W'(INVALID_LIM) : v + 1'b1;
    endfunction

    assign qs         = q_sync[SYNC_STAGES-1];
    assign qbs        = qbar_sync[SYNC_STAGES-1];
    assign good_set   = qs & ~qbs;
    assign good_reset = ~qs & qbs;
    assign bad        = (qs == qbs);
    // Current bad sample counts toward the limit, hence the +1.
    assign at_limit   = bad && ((int'(bad_cnt) + 1) >= INVALID_LIM);

    always_comb begin
        state_nxt = state_r;
        if (good_set) begin
            state_nxt = ST_SET;
        end else if (good_reset) begin
            state_nxt = ST_RESET;
        end else if (at_limit) begin
            state_nxt = ST_INVALID;
        end
    end

    assign enter_set     = (state_nxt == ST_SET)     && (state_r != ST_SET);
    assign enter_reset   = (state_nxt == ST_RESET)   && (state_r != ST_RESET);
    assign enter_invalid = (state_nxt == ST_INVALID) && (state_r != ST_INVALID);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_sync        <= '0;
            qbar_sync     <= '1;
            bad_cnt       <= '0;
            state_r       <= ST_UNKNOWN;
            set_count     <= '0;
            reset_count   <= '0;
            change_pulse  <= 1'b0;
            invalid_pulse <= 1'b0;
            invalid_flag  <= 1'b0;
        end else begin
            q_sync        <= {q_sync[SYNC_STAGES-2:0], q_in};
            qbar_sync     <= {qbar_sync[SYNC_STAGES-2:0], qbar_in};
            bad_cnt       <= bad ? bad_inc(bad_cnt) : '0;
            state_r       <= state_nxt;
            change_pulse  <= (state_nxt != state_r);
            invalid_pulse <= enter_invalid;
            // Clear takes priority over a coincident increment or INVALID entry.
            if (clr_counts) begin
                set_count    <= '0;
                reset_count  <= '0;
                invalid_flag <= 1'b0;
            end else begin
                if (enter_set)     set_count    <= sat_inc(set_count);
                if (enter_reset)   reset_count  <= sat_inc(reset_count);
                if (enter_invalid) invalid_flag <= 1'b1;
            end
        end
    end

    assign state = state_r;

endmodule
